// File: rtl/sprite_motion_fsm.sv
// sprite_motion_fsm: stand/run/jump motion controller with gravity, clamped x,
// pause and run-cycle animation; all state advances on update-qualified edges.
module sprite_motion_fsm #(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 9,
  parameter int V_WIDTH      = 6,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 223,
  parameter int X_START      = 16,
  parameter int X_STEP       = 2,
  parameter int FLOOR_Y      = 200,
  parameter int JUMP_VEL     = 8,
  parameter int GRAVITY      = 1,
  parameter int MAX_FALL     = 15,
  parameter int RUN_FRAMES   = 4,
  parameter int FRAME_DIV    = 4,
  parameter int ROM_STAND    = 0,
  parameter int ROM_RUN_BASE = 1,
  parameter int ROM_JUMP     = 5,
  parameter int ROM_FALL     = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               update,
  input  logic [3:0]         keys,
  output logic [X_WIDTH-1:0] xSprite,
  output logic [Y_WIDTH-1:0] ySprite,
  output logic [3:0]         ROMId,
  output logic [1:0]         state,
  output logic               airborne
);
  typedef enum logic [1:0] {ST_STAND = 2'd0, ST_RUN = 2'd1, ST_JUMP = 2'd2} state_t;
  localparam int XW1 = X_WIDTH + 1;
  localparam int YW2 = Y_WIDTH + 2;
  localparam int FW  = (RUN_FRAMES > 1) ? $clog2(RUN_FRAMES) : 1;
  localparam int DW  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [XW1-1:0]            X_MAX_W  = XW1'(X_MAX);
  localparam logic [XW1-1:0]            X_LO_W   = XW1'(X_MIN + X_STEP);
  localparam logic signed [YW2-1:0]     FLOOR_W  = YW2'(FLOOR_Y);
  localparam logic signed [V_WIDTH:0]   MAXF_W   = (V_WIDTH+1)'(MAX_FALL);
  localparam logic signed [V_WIDTH-1:0] V_JUMP   = V_WIDTH'(-JUMP_VEL);
  localparam logic [FW-1:0]             F_LAST   = FW'(RUN_FRAMES - 1);
  localparam logic [DW-1:0]             D_LAST   = DW'(FRAME_DIV - 1);
  state_t                    r_state, w_n_state;
  logic [X_WIDTH-1:0]        r_x, w_n_x;
  logic [Y_WIDTH-1:0]        r_y, w_n_y;
  logic signed [V_WIDTH-1:0] r_vel, w_n_vel, w_vel_inc;
  logic [FW-1:0]             r_frame, w_n_frame;
  logic [DW-1:0]             r_div, w_n_div;
  logic [3:0]                r_rom, w_n_rom;
  logic                      r_jump_held;
  logic                      w_right, w_left, w_dir, w_edge;
  logic [XW1-1:0]            w_x_inc;
  logic signed [YW2-1:0]     w_y_sum;
  logic signed [V_WIDTH:0]   w_v_sum;
  assign w_right = ~keys[1];
  assign w_left  = ~keys[2];
  assign w_dir   = w_right ^ w_left;
  assign w_edge  = ~keys[0] & ~r_jump_held;
  assign w_x_inc = {1'b0, r_x} + XW1'(X_STEP);
  assign w_n_x   = (w_right & ~w_left) ? ((w_x_inc > X_MAX_W) ? X_MAX_W[X_WIDTH-1:0] : w_x_inc[X_WIDTH-1:0]) :
                   (w_left & ~w_right) ? (({1'b0, r_x} < X_LO_W) ? X_WIDTH'(X_MIN) : r_x - X_WIDTH'(X_STEP)) : r_x;
  assign w_y_sum   = $signed({2'b00, r_y}) + $signed({{(YW2-V_WIDTH){r_vel[V_WIDTH-1]}}, r_vel});
  assign w_v_sum   = $signed({r_vel[V_WIDTH-1], r_vel}) + $signed((V_WIDTH+1)'(GRAVITY));
  assign w_vel_inc = (w_v_sum > MAXF_W) ? MAXF_W[V_WIDTH-1:0] : w_v_sum[V_WIDTH-1:0];
  always_comb begin
    w_n_state = r_state;
    w_n_y     = r_y;
    w_n_vel   = r_vel;
    w_n_frame = r_frame;
    w_n_div   = r_div;
    case (r_state)
      ST_STAND, ST_RUN: begin
        if (w_edge) begin
          w_n_state = ST_JUMP;
          w_n_vel   = V_JUMP;
        end else if (!w_dir) begin
          w_n_state = ST_STAND;
        end else if (r_state == ST_STAND) begin
          w_n_state = ST_RUN;
          w_n_frame = '0;
          w_n_div   = '0;
        end else begin
          w_n_div = (r_div == D_LAST) ? '0 : r_div + 1'b1;
          if (r_div == D_LAST) w_n_frame = (r_frame == F_LAST) ? '0 : r_frame + 1'b1;
        end
      end
      default: begin
        if (w_y_sum[YW2-1]) begin
          w_n_y   = '0;
          w_n_vel = '0;
        end else if (w_y_sum >= FLOOR_W) begin
          w_n_y     = Y_WIDTH'(FLOOR_Y);
          w_n_vel   = '0;
          w_n_state = w_dir ? ST_RUN : ST_STAND;
          w_n_frame = '0;
          w_n_div   = '0;
        end else begin
          w_n_y   = w_y_sum[Y_WIDTH-1:0];
          w_n_vel = w_vel_inc;
        end
      end
    endcase
    w_n_rom = (w_n_state == ST_RUN)  ? 4'(ROM_RUN_BASE) + 4'(w_n_frame) :
              (w_n_state == ST_JUMP) ? (w_n_vel[V_WIDTH-1] ? 4'(ROM_JUMP) : 4'(ROM_FALL)) : 4'(ROM_STAND);
  end
  // Pause (keys[3] low) freezes every register, jump-key history included.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_STAND;
      r_x         <= X_WIDTH'(X_START);
      r_y         <= Y_WIDTH'(FLOOR_Y);
      r_vel       <= '0;
      r_frame     <= '0;
      r_div       <= '0;
      r_rom       <= 4'(ROM_STAND);
      r_jump_held <= 1'b0;
    end else if (update && keys[3]) begin
      r_state     <= w_n_state;
      r_x         <= w_n_x;
      r_y         <= w_n_y;
      r_vel       <= w_n_vel;
      r_frame     <= w_n_frame;
      r_div       <= w_n_div;
      r_rom       <= w_n_rom;
      r_jump_held <= ~keys[0];
    end
  end
  assign xSprite  = r_x;
  assign ySprite  = r_y;
  assign ROMId    = r_rom;
  assign state    = r_state;
  assign airborne = (r_state == ST_JUMP);
endmodule

// File: tb/tb_sprite_motion_fsm.sv
// tb_sprite_motion_fsm: directed checks of motion, jump arc, clamping,
// animation, pause and asynchronous reset against hand-computed values.
module tb_sprite_motion_fsm;
  logic       clock = 0, reset = 0, update = 0;
  logic [3:0] keys = 4'b1111;
  logic [7:0] xSprite;
  logic [8:0] ySprite;
  logic [3:0] ROMId;
  logic [1:0] state;
  logic       airborne;
  int checks = 0, errors = 0;

  localparam logic [3:0] K_IDLE  = 4'b1111;
  localparam logic [3:0] K_JUMP  = 4'b1110;
  localparam logic [3:0] K_RIGHT = 4'b1101;
  localparam logic [3:0] K_LEFT  = 4'b1011;
  localparam logic [3:0] K_BOTH  = 4'b1001;

  sprite_motion_fsm dut (
    .clock(clock), .reset(reset), .update(update), .keys(keys),
    .xSprite(xSprite), .ySprite(ySprite), .ROMId(ROMId), .state(state), .airborne(airborne)
  );

  always #5 clock = ~clock;

  task automatic tick(input logic [3:0] k);
    @(negedge clock);
    keys = k;
    update = 1;
    @(negedge clock);
    update = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    keys = K_IDLE;
    update = 0;
    reset = 0;
    @(negedge clock);
    reset = 1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 0;
    #1;
    checks++;
    if ({xSprite, ySprite, ROMId, state, airborne} !== {8'd16, 9'd200, 4'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state x=%0d y=%0d rom=%0d st=%0d air=%0d exp 16 200 0 0 0", xSprite, ySprite, ROMId, state, airborne);
    end
    @(negedge clock);
    reset = 1;
    repeat (10) tick(K_IDLE);
    checks++;
    if ({xSprite, ySprite, ROMId, state} !== {8'd16, 9'd200, 4'd0, 2'd0}) begin
      errors++;
      $display("FAIL idle10 x=%0d y=%0d rom=%0d st=%0d exp 16 200 0 0", xSprite, ySprite, ROMId, state);
    end
    keys = K_RIGHT & K_JUMP;
    repeat (5) @(negedge clock);
    checks++;
    if ({xSprite, state} !== {8'd16, 2'd0}) begin
      errors++;
      $display("FAIL no_update_hold x=%0d st=%0d exp 16 0", xSprite, state);
    end
    keys = K_IDLE;
    tick(K_IDLE);
  endtask

  task automatic test_jump_arc();
    int exp_y[17] = '{192, 185, 179, 174, 170, 167, 165, 164, 164, 165, 167, 170, 174, 179, 185, 192, 200};
    do_reset();
    tick(K_JUMP);
    checks++;
    if ({ySprite, state, ROMId, airborne} !== {9'd200, 2'd2, 4'd5, 1'b1}) begin
      errors++;
      $display("FAIL jump_start y=%0d st=%0d rom=%0d air=%0d exp 200 2 5 1", ySprite, state, ROMId, airborne);
    end
    for (int k = 1; k <= 17; k++) begin
      tick(K_JUMP);
      checks++;
      if (ySprite !== 9'(exp_y[k-1])) begin
        errors++;
        $display("FAIL jump_y[%0d] got %0d exp %0d", k, ySprite, exp_y[k-1]);
      end
      checks++;
      if (k < 17 && {state, ROMId} !== {2'd2, (k < 8) ? 4'd5 : 4'd6}) begin
        errors++;
        $display("FAIL jump_rom[%0d] st=%0d rom=%0d exp 2 %0d", k, state, ROMId, (k < 8) ? 5 : 6);
      end else if (k == 17 && {state, ROMId, airborne} !== {2'd0, 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL land st=%0d rom=%0d air=%0d exp 0 0 0", state, ROMId, airborne);
      end
    end
    checks++;
    if (xSprite !== 8'd16) begin
      errors++;
      $display("FAIL jump_x got %0d exp 16", xSprite);
    end
  endtask

  task automatic test_jump_hold();
    tick(K_JUMP);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL held_no_retrigger st=%0d exp 0", state);
    end
    tick(K_IDLE);
    tick(K_JUMP);
    checks++;
    if ({state, ySprite} !== {2'd2, 9'd200}) begin
      errors++;
      $display("FAIL rejump st=%0d y=%0d exp 2 200", state, ySprite);
    end
    repeat (17) tick(K_IDLE);
    checks++;
    if ({state, ySprite} !== {2'd0, 9'd200}) begin
      errors++;
      $display("FAIL rejump_land st=%0d y=%0d exp 0 200", state, ySprite);
    end
  endtask

  task automatic test_horizontal();
    logic [7:0] exp_r[3] = '{222, 223, 223};
    do_reset();
    repeat (102) tick(K_RIGHT);
    checks++;
    if ({xSprite, state} !== {8'd220, 2'd1}) begin
      errors++;
      $display("FAIL right_run x=%0d st=%0d exp 220 1", xSprite, state);
    end
    for (int i = 0; i < 3; i++) begin
      tick(K_RIGHT);
      checks++;
      if (xSprite !== exp_r[i]) begin
        errors++;
        $display("FAIL right_clamp[%0d] got %0d exp %0d", i, xSprite, exp_r[i]);
      end
    end
    repeat (111) tick(K_LEFT);
    checks++;
    if (xSprite !== 8'd1) begin
      errors++;
      $display("FAIL left_run got %0d exp 1", xSprite);
    end
    for (int i = 0; i < 2; i++) begin
      tick(K_LEFT);
      checks++;
      if ({xSprite, state} !== {8'd0, 2'd1}) begin
        errors++;
        $display("FAIL left_clamp[%0d] x=%0d st=%0d exp 0 1", i, xSprite, state);
      end
    end
    repeat (5) tick(K_RIGHT);
    for (int i = 0; i < 2; i++) begin
      tick(K_BOTH);
      checks++;
      if ({xSprite, state} !== {8'd10, 2'd0}) begin
        errors++;
        $display("FAIL both_keys[%0d] x=%0d st=%0d exp 10 0", i, xSprite, state);
      end
    end
  endtask

  task automatic test_run_anim();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      tick(K_RIGHT);
      checks++;
      if (ROMId !== ((i == 17) ? 4'd1 : 4'(1 + (i - 1) / 4))) begin
        errors++;
        $display("FAIL run_rom[%0d] got %0d exp %0d", i, ROMId, (i == 17) ? 1 : 1 + (i - 1) / 4);
      end
    end
    tick(K_IDLE);
    checks++;
    if ({state, ROMId} !== {2'd0, 4'd0}) begin
      errors++;
      $display("FAIL run_release st=%0d rom=%0d exp 0 0", state, ROMId);
    end
  endtask

  task automatic test_pause();
    int exp_y[9] = '{164, 165, 167, 170, 174, 179, 185, 192, 200};
    do_reset();
    tick(K_JUMP);
    repeat (8) tick(K_IDLE);
    for (int i = 0; i < 5; i++) begin
      tick(4'b0100);
      checks++;
      if ({ySprite, xSprite, state, ROMId} !== {9'd164, 8'd16, 2'd2, 4'd6}) begin
        errors++;
        $display("FAIL pause_freeze[%0d] y=%0d x=%0d st=%0d rom=%0d exp 164 16 2 6", i, ySprite, xSprite, state, ROMId);
      end
    end
    for (int i = 0; i < 9; i++) begin
      tick(K_IDLE);
      checks++;
      if (ySprite !== 9'(exp_y[i])) begin
        errors++;
        $display("FAIL pause_resume_y[%0d] got %0d exp %0d", i, ySprite, exp_y[i]);
      end
    end
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL pause_land st=%0d exp 0", state);
    end
    tick(K_IDLE);
    tick(4'b0110);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL pause_jump_frozen st=%0d exp 0", state);
    end
    tick(K_JUMP);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL pause_edge_kept st=%0d exp 2", state);
    end
  endtask

  task automatic test_async_reset();
    repeat (2) tick(K_IDLE);
    checks++;
    if ({ySprite, state} !== {9'd185, 2'd2}) begin
      errors++;
      $display("FAIL pre_reset y=%0d st=%0d exp 185 2", ySprite, state);
    end
    @(negedge clock);
    #1 reset = 0;
    #1;
    checks++;
    if ({ySprite, state, ROMId, airborne, xSprite} !== {9'd200, 2'd0, 4'd0, 1'b0, 8'd16}) begin
      errors++;
      $display("FAIL async_reset y=%0d st=%0d rom=%0d air=%0d x=%0d exp 200 0 0 0 16", ySprite, state, ROMId, airborne, xSprite);
    end
    @(negedge clock);
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_jump_arc();
    test_jump_hold();
    test_horizontal();
    test_run_anim();
    test_pause();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
